writeback_arbiter: RTL and testbench

Merges the two result producers of the pipelined core onto the register file's single write port (rd / write_data / reg_write). Producers are the in-order ALU/memory writeback path and the multi-cycle mul/div unit. ALU results always have priority and are never back-pressured. Mul/div results are buffered in a small FIFO and drained into idle write-port cycles. A starvation guard briefly stalls the ALU path so that buffered results always retire, and a write-after-write squash prevents an older mul/div result from overwriting a younger ALU result.

---
 rtl/writeback_arbiter.sv | 138 +++++++++++++
 tb/tb_writeback_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges the in-order ALU/memory writeback path and the multi-cycle mul/div
//   unit onto the register file's single write port. ALU results always win
//   and are never back-pressured; mul/div results wait in a small FIFO and
//   drain into idle write-port cycles. A starvation guard raises alu_stall so
//   buffered results always retire, and a write-after-write squash kills any
//   buffered mul/div result that a younger ALU result has overwritten.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   alu_valid/rd/data   ALU-path result, always accepted
//   md_valid/rd/data    mul/div result offer
//   md_ready            FIFO has room (from the registered count only)
//   alu_stall           upstream must hold alu_valid low while this is 1
//   rd/write_data       register file write address / data (registered)
//   reg_write           register file write enable (registered)
module writeback_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alu_valid,
   input  logic [4:0]         alu_rd,
   input  logic signed [63:0] alu_data,
   input  logic               md_valid,
   input  logic [4:0]         md_rd,
   input  logic signed [63:0] md_data,
   output logic               md_ready,
   output logic               alu_stall,
   output logic [4:0]         rd,
   output logic signed [63:0] write_data,
   output logic               reg_write
);

   localparam int DATA_W = 64;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

   logic                     ent_live [FIFO_DEPTH];
   logic [4:0]               ent_rd   [FIFO_DEPTH];
   logic signed [DATA_W-1:0] ent_data [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [SC_W-1:0]  starve_cnt;
   logic [SC_W-1:0]  starve_nxt;

   logic head_vld;
   logic head_live;
   logic push;
   logic push_live;
   logic pop;
   logic drain;

   assign md_ready = (count < DEPTH_C);

   always_comb begin
      head_vld  = (count != '0);
      head_live = head_vld && ent_live[rd_ptr];
      push      = md_valid && md_ready;
      // A same-cycle ALU write to the same register makes the mul/div
      // result stale before it is even stored.
      push_live = !(alu_valid && (alu_rd == md_rd));
      // Dead heads are discarded even while the ALU owns the port.
      pop       = head_vld && (!ent_live[rd_ptr] || !alu_valid);
      drain     = head_live && !alu_valid;
      starve_nxt = '0;
      if (head_live && alu_valid) begin
         starve_nxt = (starve_cnt == LIMIT_C) ? LIMIT_C : starve_cnt + SC_W'(1);
      end
   end

   // Stage p0: FIFO control, squash and starvation tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         alu_stall  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_live[i] <= 1'b0;
         end
      end else begin
         if (alu_valid) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               if (ent_rd[i] == alu_rd) begin
                  ent_live[i] <= 1'b0;
               end
            end
         end
         // The push slot is never an occupied entry, so it overrides the squash.
         if (push) begin
            ent_live[wr_ptr] <= push_live;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count      <= count + CNT_W'(push) - CNT_W'(pop);
         starve_cnt <= starve_nxt;
         alu_stall  <= (starve_nxt >= LIMIT_C);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd[wr_ptr]   <= md_rd;
         ent_data[wr_ptr] <= md_data;
      end
   end

   // Stage p1: registered write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd         <= '0;
         write_data <= '0;
         reg_write  <= 1'b0;
      end else if (alu_valid) begin
         rd         <= alu_rd;
         write_data <= alu_data;
         reg_write  <= (alu_rd != 5'd0);
      end else if (drain) begin
         rd         <= ent_rd[rd_ptr];
         write_data <= ent_data[rd_ptr];
         reg_write  <= (ent_rd[rd_ptr] != 5'd0);
      end else begin
         reg_write  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed stimulus against writeback_arbiter. A queue-based model tracks
//   the buffered mul/div results and the expected write-port outputs; one
//   process compares the DUT to it every cycle, and the directed sequence
//   pins key cycles with hand-computed literal values.
module tb_writeback_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               alu_valid = 1'b0;
   logic [4:0]         alu_rd = '0;
   logic signed [63:0] alu_data = '0;
   logic               md_valid = 1'b0;
   logic [4:0]         md_rd = '0;
   logic signed [63:0] md_data = '0;
   logic               md_ready;
   logic               alu_stall;
   logic [4:0]         rd;
   logic signed [63:0] write_data;
   logic               reg_write;

   int checks = 0;
   int errors = 0;

   writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
      .md_ready(md_ready), .alu_stall(alu_stall),
      .rd(rd), .write_data(write_data), .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          live;
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t        q[$];
   int          scnt = 0;
   logic [4:0]  e_rd = '0;
   logic [63:0] e_wd = '0;
   bit          e_we = 0;
   bit          e_stall = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         scnt = 0; e_rd = '0; e_wd = '0; e_we = 0; e_stall = 0;
      end else begin
         bit   exists, live, room;
         ent_t ne;
         exists = (q.size() > 0);
         live   = exists && q[0].live;
         room   = (q.size() < DEPTH);
         if (live && alu_valid) begin
            if (scnt < LIMIT) scnt++;
         end else begin
            scnt = 0;
         end
         e_stall = (scnt >= LIMIT);
         if (alu_valid) begin
            e_rd = alu_rd; e_wd = alu_data; e_we = (alu_rd != 0);
         end else if (live) begin
            e_rd = q[0].rd; e_wd = q[0].data; e_we = (q[0].rd != 0);
         end else begin
            e_we = 0;
         end
         if (exists && (!live || !alu_valid)) void'(q.pop_front());
         if (alu_valid) begin
            foreach (q[i]) if (q[i].rd == alu_rd) q[i].live = 0;
         end
         if (md_valid && room) begin
            ne.live = !(alu_valid && alu_rd == md_rd);
            ne.rd   = md_rd;
            ne.data = md_data;
            q.push_back(ne);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      chk("reg_write", 64'(reg_write), 64'(e_we));
      chk("rd", 64'(rd), 64'(e_rd));
      chk("write_data", write_data, e_wd);
      chk("alu_stall", 64'(alu_stall), 64'(e_stall));
      chk("md_ready", 64'(md_ready), 64'(q.size() < DEPTH));
   end

   always @(posedge clk) begin
      if (rst_n) begin
         checks++;
         assert (!(alu_valid && alu_stall)) else begin
            errors++;
            $display("FAIL protocol: alu_valid=1 while alu_stall=1 at %0t", $time);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input bit av, input logic [4:0] ard, input logic signed [63:0] adat,
                      input bit mv, input logic [4:0] mrd, input logic signed [63:0] mdat);
      @(negedge clk);
      alu_valid = av; alu_rd = ard; alu_data = adat;
      md_valid = mv; md_rd = mrd; md_data = mdat;
   endtask

   task automatic post();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
      post();
   endtask

   initial begin
      int n;
      post();
      chk("rst_reg_write", 64'(reg_write), 0);
      chk("rst_md_ready", 64'(md_ready), 1);
      chk("rst_alu_stall", 64'(alu_stall), 0);
      chk("rst_rd", 64'(rd), 0);
      chk("rst_write_data", write_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();

      // ALU only
      cyc(1, 5, -3, 0, 0, 0); post();
      chk("alu_we", 64'(reg_write), 1);
      chk("alu_rd", 64'(rd), 5);
      chk("alu_data", write_data, 64'hFFFF_FFFF_FFFF_FFFD);
      idle();
      chk("hold_we", 64'(reg_write), 0);
      chk("hold_rd", 64'(rd), 5);
      chk("hold_data", write_data, 64'hFFFF_FFFF_FFFF_FFFD);

      // FIFO fill and drain
      for (int k = 0; k < 4; k++) begin
         cyc(1, 5'(20 + k), 64'(k), 1, 5'(1 + k), 64'(100 + k)); post();
      end
      chk("full_md_ready", 64'(md_ready), 0);
      for (int k = 0; k < 4; k++) begin
         idle();
         chk("drain_we", 64'(reg_write), 1);
         chk("drain_rd", 64'(rd), 64'(1 + k));
         chk("drain_data", write_data, 64'(100 + k));
         chk("drain_md_ready", 64'(md_ready), 1);
      end
      idle();
      chk("drained_we", 64'(reg_write), 0);

      // WAW squash: buffered entry overwritten by a younger ALU result
      cyc(0, 0, 0, 1, 7, 11); post();
      cyc(1, 7, 22, 0, 0, 0); post();
      chk("waw_alu_data", write_data, 22);
      idle();
      chk("waw_dead_we", 64'(reg_write), 0);
      idle();
      chk("waw_idle_we", 64'(reg_write), 0);
      chk("waw_keep_data", write_data, 22);
      // same-cycle collision
      cyc(1, 9, 33, 1, 9, 44); post();
      chk("same_rd", 64'(rd), 9);
      chk("same_data", write_data, 33);
      idle();
      chk("same_dead_we", 64'(reg_write), 0);
      idle();
      chk("same_idle_data", write_data, 33);

      // Starvation
      cyc(0, 0, 0, 1, 12, 55); post();
      n = 0;
      while (!alu_stall && n < 20) begin
         cyc(1, 13, 64'(n), 0, 0, 0); post();
         n++;
      end
      chk("starve_cycles", 64'(n), 8);
      chk("starve_stall", 64'(alu_stall), 1);
      idle();
      chk("starve_we", 64'(reg_write), 1);
      chk("starve_rd", 64'(rd), 12);
      chk("starve_data", write_data, 55);
      idle();
      chk("starve_clear", 64'(alu_stall), 0);

      // x0 writes
      cyc(1, 0, 77, 0, 0, 0); post();
      chk("x0_alu_we", 64'(reg_write), 0);
      cyc(0, 0, 0, 1, 0, 88); post();
      idle();
      chk("x0_md_we", 64'(reg_write), 0);
      cyc(0, 0, 0, 1, 6, 99); post();
      idle();
      chk("after_x0_rd", 64'(rd), 6);
      chk("after_x0_data", write_data, 99);

      // Reset mid-drain
      for (int k = 0; k < 3; k++) begin
         cyc(1, 5'(21 + k), 64'(k), 1, 5'(1 + k), 64'(200 + k)); post();
      end
      idle();
      chk("pre_rst_data", write_data, 200);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_we", 64'(reg_write), 0);
      chk("async_rst_md_ready", 64'(md_ready), 1);
      chk("async_rst_rd", 64'(rd), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         idle();
         chk("post_rst_we", 64'(reg_write), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
